// File: rtl/otter_intc.sv
// MMIO interrupt controller: synchronizes external sources, latches them into
// PENDING, masks with ENABLE and drives the MCU interrupt vector.
module otter_intc #(
  parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
  parameter int unsigned N_SRC       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_src,
  input  logic        i_iobus_re,
  input  logic        i_iobus_we,
  input  logic [3:0]  i_iobus_sel,
  input  logic [31:0] i_iobus_addr,
  input  logic [31:0] i_iobus_data,
  output logic [31:0] o_iobus_data,
  output logic [31:0] o_intrpt,
  output logic        o_irq
);

  localparam logic [31:0] IMPL = 32'hFFFF_FFFF >> (32 - N_SRC);

  typedef enum logic [2:0] {
    OFF_PEND   = 3'd0,
    OFF_EN     = 3'd1,
    OFF_SWTRIG = 3'd2,
    OFF_RAW    = 3'd3,
    OFF_CLAIM  = 3'd4,
    OFF_MODE   = 3'd5,
    OFF_RSV6   = 3'd6,
    OFF_RSV7   = 3'd7
  } off_e;

  logic [SYNC_STAGES-1:0][31:0] sync_q;
  logic [31:0] sync, prev_q;
  logic [31:0] hw_set_q, hw_set_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] enable_q, enable_d;
  logic [31:0] mode_q, mode_d;
  logic [31:0] rdata_q, rdata_d;

  logic        hit, wr, rd;
  off_e        off;
  logic [31:0] wmask, wbits, act, claim_mask, claim_val, clr, sw_set;
  logic        found;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^i_iobus_addr[1:0];

  assign sync  = sync_q[SYNC_STAGES-1];
  assign hit   = (i_iobus_addr[31:5] == BASE_ADDR[31:5]);
  assign off   = off_e'(i_iobus_addr[4:2]);
  assign wr    = i_iobus_we & hit;
  assign rd    = i_iobus_re & hit;
  assign wmask = {{8{i_iobus_sel[3]}}, {8{i_iobus_sel[2]}},
                  {8{i_iobus_sel[1]}}, {8{i_iobus_sel[0]}}};
  assign wbits = i_iobus_data & wmask & IMPL;
  assign act   = pending_q & enable_q;

  always_comb begin
    claim_mask = '0;
    claim_val  = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (act[i] && !found) begin
        found         = 1'b1;
        claim_mask[i] = 1'b1;
        claim_val     = i + 32'd1;
      end
    end
  end

  always_comb begin
    // prev_q tracks sync every cycle regardless of mode, so a level->edge
    // switch never sees a stale history bit and cannot fabricate an edge.
    hw_set_d = ((sync & ~prev_q & mode_q) | (sync & ~mode_q)) & IMPL;

    sw_set = '0;
    clr    = '0;
    if (wr && off == OFF_SWTRIG) sw_set = wbits;
    if (wr && off == OFF_PEND)   clr    = wbits;
    if (rd && off == OFF_CLAIM)  clr    = clr | claim_mask;

    // Sets are OR-ed in after the clear so they always win.
    pending_d = ((pending_q & ~clr) | sw_set | hw_set_q) & IMPL;

    enable_d = enable_q;
    mode_d   = mode_q;
    if (wr && off == OFF_EN)   enable_d = ((enable_q & ~wmask) | (i_iobus_data & wmask)) & IMPL;
    if (wr && off == OFF_MODE) mode_d   = ((mode_q & ~wmask) | (i_iobus_data & wmask)) & IMPL;

    rdata_d = '0;
    if (rd) begin
      case (off)
        OFF_PEND:  rdata_d = pending_q;
        OFF_EN:    rdata_d = enable_q;
        OFF_RAW:   rdata_d = sync & IMPL;
        OFF_CLAIM: rdata_d = claim_val;
        OFF_MODE:  rdata_d = mode_q;
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q    <= '0;
      prev_q    <= '0;
      hw_set_q  <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= IMPL;
      rdata_q   <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], i_src};
      prev_q    <= sync;
      hw_set_q  <= hw_set_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      rdata_q   <= rdata_d;
    end
  end

  assign o_iobus_data = rdata_q;
  assign o_intrpt     = act;
  assign o_irq        = |act;

endmodule

// File: tb/tb_otter_intc.sv
// Self-checking bench for otter_intc: register table after reset plus
// hand-written sequences for latency, claim, masking, level mode and races.
module tb_otter_intc;

  localparam logic [31:0] BASE = 32'h0002_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] src = '0;
  logic        re = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, intrpt;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [31:0] exp; string name; } sb_t;
  sb_t sbq[$];

  typedef struct { logic [4:0] off; logic [31:0] exp; } vec_t;
  vec_t vt[8];

  otter_intc #(.BASE_ADDR(BASE), .N_SRC(32), .SYNC_STAGES(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_src        (src),
    .i_iobus_re   (re),
    .i_iobus_we   (we),
    .i_iobus_sel  (sel),
    .i_iobus_addr (addr),
    .i_iobus_data (wdata),
    .o_iobus_data (rdata),
    .o_intrpt     (intrpt),
    .o_irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout reached, required end of test");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // All bus tasks start and end at a negedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    we = 1'b1; addr = a; wdata = d; sel = s;
    @(negedge clk);
    we = 1'b0; sel = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    sb_t e;
    re = 1'b1; addr = a;
    sbq.push_back('{exp, name});
    @(negedge clk);
    re = 1'b0;
    e = sbq.pop_front();
    check(e.name, rdata, e.exp);
  endtask

  task automatic bus_rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp, input string name);
    sb_t e;
    re = 1'b1; we = 1'b1; addr = a; wdata = d; sel = 4'hF;
    sbq.push_back('{exp, name});
    @(negedge clk);
    re = 1'b0; we = 1'b0; sel = '0;
    e = sbq.pop_front();
    check(e.name, rdata, e.exp);
  endtask

  initial begin
    vt[0] = '{5'h00, 32'h0};
    vt[1] = '{5'h04, 32'h0};
    vt[2] = '{5'h08, 32'h0};
    vt[3] = '{5'h0C, 32'h0};
    vt[4] = '{5'h10, 32'h0};
    vt[5] = '{5'h14, 32'hFFFF_FFFF};
    vt[6] = '{5'h18, 32'h0};
    vt[7] = '{5'h1C, 32'h0};

    // 1: reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    for (int i = 0; i < 8; i++) begin
      bus_read(BASE + 32'(vt[i].off), vt[i].exp, $sformatf("reset_reg_%0h", vt[i].off));
      check("reset_intrpt", intrpt, 32'h0);
    end
    check("rdata_idle_zero", rdata, 32'h0);
    bus_read(BASE + 32'h20, 32'h0, "out_of_window_read");

    // 2: edge latency and W1C
    bus_write(BASE + 32'h04, 32'hFFFF_0888, 4'hF);
    src = 32'h0000_0008;
    repeat (3) @(negedge clk);
    check("latency_before", intrpt, 32'h0);
    @(negedge clk);
    check("latency_at", intrpt, 32'h0000_0008);
    src = '0;
    repeat (4) @(negedge clk);
    check("edge_sticky", intrpt, 32'h0000_0008);
    bus_write(BASE + 32'h00, 32'h8, 4'hF);
    check("w1c_clears", intrpt, 32'h0);

    // 3: out-of-window write ignored, SWTRIG and CLAIM
    bus_write(BASE + 32'h24, 32'hFFFF_FFFF, 4'hF);
    bus_read(BASE + 32'h04, 32'hFFFF_0888, "oow_write_ignored");
    bus_write(BASE + 32'h08, 32'h0001_0080, 4'hF);
    bus_read(BASE + 32'h08, 32'h0, "swtrig_reads_0");
    bus_read(BASE + 32'h10, 32'd8, "claim_bit7");
    check("irq_after_claim1", {31'b0, irq}, 32'h1);
    bus_read(BASE + 32'h10, 32'd17, "claim_bit16");
    check("irq_after_claim2", {31'b0, irq}, 32'h0);
    bus_read(BASE + 32'h10, 32'd0, "claim_none");

    // 4: masked source stays pending
    bus_write(BASE + 32'h04, 32'h0, 4'hF);
    src = 32'h0000_0800;
    repeat (2) @(negedge clk);
    src = '0;
    repeat (6) @(negedge clk);
    bus_read(BASE + 32'h00, 32'h0000_0800, "masked_pending");
    check("masked_intrpt", intrpt, 32'h0);
    bus_write(BASE + 32'h04, 32'h800, 4'hF);
    check("enable_unmasks", intrpt, 32'h0000_0800);
    bus_write(BASE + 32'h00, 32'h800, 4'hF);

    // 5: level mode, byte lanes
    bus_write(BASE + 32'h14, 32'h0, 4'hF);
    bus_write(BASE + 32'h04, 32'h1, 4'hF);
    src = 32'h1;
    repeat (5) @(negedge clk);
    bus_write(BASE + 32'h00, 32'h1, 4'hF);
    bus_read(BASE + 32'h00, 32'h1, "level_w1c_ineffective");
    src = '0;
    repeat (5) @(negedge clk);
    bus_write(BASE + 32'h00, 32'h1, 4'hF);
    bus_read(BASE + 32'h00, 32'h0, "level_w1c_after_drop");
    bus_write(BASE + 32'h04, 32'hFFFF_FFFF, 4'b0010);
    bus_read(BASE + 32'h04, 32'h0000_FF01, "byte_lane_write");
    bus_write(BASE + 32'h04, 32'h0, 4'b0000);
    bus_read(BASE + 32'h04, 32'h0000_FF01, "sel_zero_noop");
    bus_write(BASE + 32'h14, 32'hFFFF_FFFF, 4'hF);
    bus_read(BASE + 32'h00, 32'h0, "no_spurious_edge");

    // 6: edge set races W1C, re+we, async reset mid-read
    bus_write(BASE + 32'h04, 32'h8, 4'hF);
    src = 32'h8;
    repeat (3) @(negedge clk);
    check("race_pre", intrpt, 32'h0);
    bus_write(BASE + 32'h00, 32'h8, 4'hF);
    check("set_beats_w1c", intrpt, 32'h8);
    src = '0;
    bus_rw(BASE + 32'h04, 32'hF, 32'h8, "rw_pre_write_data");
    bus_read(BASE + 32'h04, 32'hF, "rw_write_committed");
    re = 1'b1; addr = BASE + 32'h04;
    @(posedge clk);
    #1;
    check("midread_data", rdata, 32'hF);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_intrpt", intrpt, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    re = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(BASE + 32'h04, 32'h0, "rst_enable");
    bus_read(BASE + 32'h00, 32'h0, "rst_pending");
    bus_read(BASE + 32'h14, 32'hFFFF_FFFF, "rst_mode");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/otter_intc.md
Name: otter_intc

Overview:
- MMIO interrupt controller on the OTTER SoC external IO bus.
- Captures up to 32 external interrupt sources, latches them into a pending register, masks them with an enable register and drives the masked vector into the MCU's `i_intrpt` input.
- Firmware configures, inspects, claims and clears interrupts through word-addressed registers. This makes it the hardware responder and interrupt source that replaces a bench-driven interrupt generator.

Parameters:
- BASE_ADDR, 32'h0002_0000, base byte address of the 32-byte register window; must be 32-byte aligned.
- N_SRC, 32, number of implemented sources (1..32); bits at and above N_SRC read 0 and ignore writes.
- SYNC_STAGES, 2, flip-flop synchronizer depth on each source input (≥2).

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_src  input  32  raw external interrupt lines, asynchronous to i_clk.
- i_iobus_re  input  1  bus read strobe, single cycle.
- i_iobus_we  input  1  bus write strobe, single cycle.
- i_iobus_sel  input  4  write byte enables; bit b gates wdata[8b+7:8b].
- i_iobus_addr  input  32  byte address.
- i_iobus_data  input  32  write data.
- o_iobus_data  output  32  read data.
- o_intrpt  output  32  pending & enable, to MCU `i_intrpt`.
- o_irq  output  1  OR-reduction of o_intrpt.

Behaviour:
- Register map, offsets from BASE_ADDR; word access only, addr[1:0] ignored:
  - 0x00 PENDING: R; W1C per enabled byte lane.
  - 0x04 ENABLE: RW.
  - 0x08 SWTRIG: W1S into PENDING; reads 0.
  - 0x0C RAW: R, synchronized source levels.
  - 0x10 CLAIM: R, returns index+1 of the lowest-numbered bit set in pending & enable, or 0 if none. A read of CLAIM clears that pending bit.
  - 0x14 MODE: RW, 1=edge, 0=level per source.
  - 0x18–0x1C: reserved; read 0, writes ignored.
- Addresses outside [BASE_ADDR, BASE_ADDR+0x1F]: no state change; o_iobus_data stays 0.
- Reset (i_rst_n low, asynchronous):
  - PENDING=0, ENABLE=0, MODE=all-ones (edge), synchronizers and edge-history=0.
  - o_iobus_data=0, o_intrpt=0, o_irq=0.
  - Deassertion is taken synchronously by the surrounding reset logic. An in-flight read or write is abandoned with no state change.
- Source path:
  - Each i_src bit passes through SYNC_STAGES flops to give sync[i]; a 1-flop history gives prev[i].
  - Edge mode: sync & ~prev sets PENDING[i] on the next edge.
  - Level mode: PENDING[i] is set every cycle sync[i]=1; W1C is ineffective while the level is held.
- PENDING update priority per bit, highest first:
  1. Hardware set (edge or level).
  2. SWTRIG set.
  3. W1C clear or CLAIM clear.

  Set wins over a clear in the same cycle.
- Latency:
  - A rising i_src sampled at edge k appears on o_intrpt at edge k+SYNC_STAGES+1; o_intrpt is combinational from the PENDING and ENABLE flops.
  - ENABLE or PENDING writes take effect on o_intrpt at the edge that commits the write.
- Reads:
  - o_iobus_data is registered and presents the register value on the cycle after i_iobus_re.
  - o_iobus_data returns to 0 on the following cycle and in every non-read cycle.
  - The value read is the pre-update state of that edge. The CLAIM clear commits at the same edge the read data is registered.
- Writes:
  - Commit at the edge where i_iobus_we=1, honouring i_iobus_sel per byte.
  - sel=4'b0000 is a no-op.
- re and we asserted in the same cycle: the write commits and the read returns pre-write data.
- Bits ≥ N_SRC: constant 0 in all registers and outputs.
- MODE change edge→level while a bit is pending: the pending bit is kept. On a level→edge change, prev is loaded with sync so that no spurious edge is generated.
- o_irq = |o_intrpt, combinational.

Test Plan:
1. Reset, then read every offset → all read 0 except MODE=32'hFFFF_FFFF. o_intrpt=0 throughout.
2. ENABLE=32'hFFFF_0888; pulse i_src=32'h0000_0008 for 4 cycles → o_intrpt=32'h0000_0008 exactly SYNC_STAGES+1 edges after the first sampled edge, and it stays set after the pulse ends. Write 0x8 to PENDING → o_intrpt=0 on the next cycle.
3. Write SWTRIG=32'h0001_0080 with ENABLE=32'hFFFF_0888 → CLAIM reads 8 (bit 7), then reads 17 (bit 16), then reads 0. o_irq drops after the second claim.
4. ENABLE=0; pulse i_src bit 11 → PENDING=32'h0000_0800 and o_intrpt=0. Then write ENABLE=32'h800 → o_intrpt=32'h800 the next cycle.
5. Level mode: MODE=0, ENABLE=1, hold i_src[0]=1 → W1C of bit 0 leaves PENDING[0]=1. Drop i_src[0], then W1C → PENDING[0]=0.
6. Edge on bit 3 arrives in the same cycle as a W1C of bit 3 → PENDING[3] remains 1. Assert i_rst_n=0 mid-read → o_iobus_data=0 and all registers return to reset values immediately.
